mul_div_unit: RTL and testbench

- Iterative multiply/divide unit that owns the HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO.
- Sits directly downstream of registerFile. Operands come straight from readData1 (rs) and readData2 (rt).
- The hi/lo outputs feed the writeback mux back into writeRegisterData.
- busy stalls the pc register while an operation is in flight.

---
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO writes.
// Optional MULDIV_FAST_ZERO_EN: zero-operand launches commit immediately and skip CALC.
//
// state | meaning
// IDLE  | waiting for start or MTHI/MTLO
// CALC  | one multiply/divide step per edge, counter running down
// DONE  | result committed, done pulses; start may relaunch directly
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstd,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic                  writeHi,
    input  logic                  writeLo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          isDiv, negQ, negR, divZero;
    logic [W-1:0]  operand, accHi, accLo, srcALat;
    logic [W-1:0]  hiReg, loReg;

    logic          signedOp, divOp, aNeg, bNeg, launch, takeFast;
    logic [W-1:0]  absA, absB;
    logic [W:0]    sum, shifted;
    logic          geq;
    logic [W-1:0]  nextHi, nextLo, resHi, resLo;
    logic [2*W-1:0] prod;

    assign signedOp = ~op[0];
    assign divOp    = op[1];
    assign aNeg     = signedOp & srcA[W-1];
    assign bNeg     = signedOp & srcB[W-1];
    assign absA     = aNeg ? -srcA : srcA;
    assign absB     = bNeg ? -srcB : srcB;
    assign launch   = start && (state == IDLE || state == DONE);

`ifdef MULDIV_FAST_ZERO_EN
    assign takeFast = divOp ? (srcA == '0 && srcB != '0) : (srcA == '0 || srcB == '0);
`else
    assign takeFast = 1'b0;
`endif

    // Shared datapath: accHi/accLo hold partial product, or remainder/quotient during divide.
    always_comb begin
        sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        shifted = {accHi, accLo[W-1]};
        geq     = shifted >= {1'b0, operand};
        if (isDiv) begin
            nextHi = geq ? (shifted[W-1:0] - operand) : shifted[W-1:0];
            nextLo = {accLo[W-2:0], geq};
        end else begin
            nextHi = sum[W:1];
            nextLo = {sum[0], accLo[W-1:1]};
        end
    end

    always_comb begin
        prod  = {nextHi, nextLo};
        resHi = '0;
        resLo = '0;
        if (!isDiv) begin
            {resHi, resLo} = negQ ? -prod : prod;
        end else if (divZero) begin
            resHi = srcALat;
            resLo = '1;
        end else begin
            resHi = negR ? -nextHi : nextHi;
            resLo = negQ ? -nextLo : nextLo;
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state   <= IDLE;
            cnt     <= '0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            operand <= '0;
            accHi   <= '0;
            accLo   <= '0;
            srcALat <= '0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch && takeFast) begin
                        hiReg <= '0;
                        loReg <= '0;
                        state <= DONE;
                    end else if (launch) begin
                        isDiv   <= divOp;
                        negQ    <= aNeg ^ bNeg;
                        negR    <= aNeg;
                        divZero <= divOp && (srcB == '0);
                        srcALat <= srcA;
                        operand <= divOp ? absB : absA;
                        accLo   <= divOp ? absA : absB;
                        accHi   <= '0;
                        cnt     <= CNT_LOAD;
                        state   <= CALC;
                    end else begin
                        if (writeHi) hiReg <= srcA;
                        if (writeLo) loReg <= srcA;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    accHi <= nextHi;
                    accLo <= nextLo;
                    cnt   <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        hiReg <= resHi;
                        loReg <= resLo;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hi   = hiReg;
    assign lo   = loReg;
    assign busy = (state == CALC);
    assign done = (state == DONE);
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO, a monitor checks on done.
module tb_mul_div_unit;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srcA = '0, srcB = '0;
    logic        writeHi = 1'b0, writeLo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int failures = 0;
    logic [63:0] expQ[$];

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstd(rstd), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .writeHi(writeHi), .writeLo(writeLo), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rstd && done) begin
            if (expQ.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = expQ.pop_front();
                chk("result_hi", hi, e[63:32]);
                chk("result_lo", lo, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                         input int disturbAt, input logic [31:0] prevHi);
        int busyCnt;
        bit seen;
        busyCnt = 0;
        seen = 0;
        op = o; srcA = a; srcB = b; start = 1'b1;
        expQ.push_back({eHi, eLo});
        @(posedge clk);
        #1;
        start = 1'b0; writeHi = 1'b0; writeLo = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (disturbAt > 0 && i == disturbAt + 1) begin
                start = 1'b0; writeHi = 1'b0;
                chk({name, "_hi_held"}, hi, prevHi);
            end
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busyCnt++;
            if (disturbAt > 0 && i == disturbAt) begin
                writeHi = 1'b1; start = 1'b1; op = MULT;
                srcA = 32'hAAAA0000; srcB = 32'h00000003;
            end
        end
        chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({name, "_busy_cycles"}, busyCnt, 32'd32);
    endtask

    initial begin
        #4000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rstd = 1'b1;
        @(negedge clk);

        runOp("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        runOp("mult_neg",  MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
        runOp("div_neg",   DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        runOp("divu_zero", DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 0, 0);
        runOp("div_wrap",  DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0);
        runOp("div_zero",  DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, 0);
        runOp("divu_dist", DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10, 32'hFFFFFFF9);

        // Reset mid-operation: nothing queued, result discarded.
        op = MULT; srcA = 32'd5; srcB = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rstd = 1'b0;
        #1;
        chk("midreset_hi", hi, 32'h0);
        chk("midreset_lo", lo, 32'h0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        expQ.delete();
        @(negedge clk);
        rstd = 1'b1;

        @(negedge clk);
        writeLo = 1'b1; srcA = 32'h00000042;
        @(posedge clk);
        #1 writeLo = 1'b0;
        chk("mtlo_lo", lo, 32'h00000042);
        chk("mtlo_hi", hi, 32'h0);

        @(negedge clk);
        writeHi = 1'b1; writeLo = 1'b1; srcA = 32'h00001234;
        @(posedge clk);
        #1 begin writeHi = 1'b0; writeLo = 1'b0; end
        chk("mtboth_hi", hi, 32'h00001234);
        chk("mtboth_lo", lo, 32'h00001234);

        @(negedge clk);
        writeHi = 1'b1;
        runOp("start_wins", MULTU, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 0, 0);

        // Write accepted in the DONE cycle.
        writeHi = 1'b1; srcA = 32'h00000055;
        @(posedge clk);
        #1 writeHi = 1'b0;
        chk("done_mthi_hi", hi, 32'h00000055);
        chk("done_mthi_lo", lo, 32'h0000000C);
        chk("done_after_busy", {31'd0, busy}, 32'd0);

        repeat (2) @(negedge clk);
        chk("queue_empty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
